// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the asynchronous FIFO pointer logic.
//   ADDRSIZE_DEFAULT : default FIFO address width (depth = 2**ADDRSIZE)
//   bin2gray         : binary -> reflected Gray code
//   gray2bin         : reflected Gray code -> binary
// Both conversions operate on a 32-bit container. Narrower pointers are
// zero-extended on the way in and truncated on the way out. Leading zero
// bits map to leading zero bits in either direction, so the result is
// exact for any pointer width up to 32 (ADDRSIZE up to 31).
// ---------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/custom_wptr_full.sv
// ---------------------------------------------------------------------------
// custom_wptr_full
// Write-side pointer and status generator for an asynchronous FIFO. The
// whole block runs in the write clock domain.
//
// Parameters
//   ADDRSIZE     : FIFO address width, depth = 2**ADDRSIZE (2..31)
//   AFULL_THRESH : fill level at or above which wafull_o asserts
//
// Ports
//   wclk_i           in   1           write clock
//   wrst_n_i         in   1           async-assert, active-low reset
//   winc_i           in   1           write request
//   wovf_clr_i       in   1           clears the sticky overflow flag
//   rptr_sync2_wrclk in   ADDRSIZE+1  Gray read pointer, already in wclk_i
//   waddr_o          out  ADDRSIZE    binary write address to the memory
//   wptr_g           out  ADDRSIZE+1  Gray write pointer, to the read side
//   wfull_o          out  1           FIFO full (registered)
//   wafull_o         out  1           FIFO almost full (registered)
//   wlevel_o         out  ADDRSIZE+1  write-side occupancy, 0..2**ADDRSIZE
//   wovf_o           out  1           sticky: write attempted while full
// ---------------------------------------------------------------------------
module custom_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE     = ADDRSIZE_DEFAULT,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk_i,
    input  logic                wrst_n_i,
    input  logic                winc_i,
    input  logic                wovf_clr_i,
    input  logic [ADDRSIZE:0]   rptr_sync2_wrclk,
    output logic [ADDRSIZE-1:0] waddr_o,
    output logic [ADDRSIZE:0]   wptr_g,
    output logic                wfull_o,
    output logic                wafull_o,
    output logic [ADDRSIZE:0]   wlevel_o,
    output logic                wovf_o
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rptr_full_cmp;
    logic          wr_ok;
    logic          full_next;
    logic          afull_next;
    logic          ovf_next;

    // A request while full is dropped and never moves the pointer.
    assign wr_ok      = winc_i & ~wfull_o;
    assign wbin_next  = wbin + PW'(wr_ok);
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));

    // Address comes straight from the register so it is usable in the same
    // cycle as winc_i.
    assign waddr_o = wbin[ADDRSIZE-1:0];

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the read pointer with its two MSBs
    // inverted and the remaining bits equal.
    assign rptr_full_cmp = {~rptr_sync2_wrclk[ADDRSIZE:ADDRSIZE-1],
                            rptr_sync2_wrclk[ADDRSIZE-2:0]};
    assign full_next     = (wgray_next == rptr_full_cmp);

    // Modular subtraction keeps the level correct across pointer wraps.
    assign rbin       = PW'(gray2bin(32'(rptr_sync2_wrclk)));
    assign level_next = wbin_next - rbin;
    assign afull_next = (33'(level_next) >= 33'(AFULL_THRESH));

    // Set has priority over clear.
    assign ovf_next = (winc_i & wfull_o) | (wovf_o & ~wovf_clr_i);

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            wbin     <= '0;
            wptr_g   <= '0;
            wfull_o  <= 1'b0;
            wafull_o <= 1'b0;
            wlevel_o <= '0;
            wovf_o   <= 1'b0;
        end else begin
            wbin     <= wbin_next;
            wptr_g   <= wgray_next;
            wfull_o  <= full_next;
            wafull_o <= afull_next;
            wlevel_o <= level_next;
            wovf_o   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_custom_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_custom_wptr_full
// Self-checking bench for custom_wptr_full (ADDRSIZE=4, AFULL_THRESH=12).
// A counter-based model (accepted writes and reads kept as plain binary
// counts) predicts every output on every cycle. Directed sequences pin the
// model with literal expectations, then a randomized phase exercises mixed
// writes, read advances, overflow and clears.
// ---------------------------------------------------------------------------
module tb_custom_wptr_full;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;
    localparam int MODV  = 32;
    localparam int TH    = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          winc  = 1'b0;
    logic          clr   = 1'b0;
    logic [PW-1:0] rptr  = '0;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr_g;
    logic          wfull;
    logic          wafull;
    logic [PW-1:0] wlevel;
    logic          wovf;

    custom_wptr_full #(.ADDRSIZE(AW), .AFULL_THRESH(TH)) dut (
        .wclk_i           (clk),
        .wrst_n_i         (rst_n),
        .winc_i           (winc),
        .wovf_clr_i       (clr),
        .rptr_sync2_wrclk (rptr),
        .waddr_o          (waddr),
        .wptr_g           (wptr_g),
        .wfull_o          (wfull),
        .wafull_o         (wafull),
        .wlevel_o         (wlevel),
        .wovf_o           (wovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: counts of accepted writes and of reads, mod 2*DEPTH.
    int rd_cnt  = 0;
    int m_wbin  = 0;
    int m_level = 0;
    bit m_full  = 1'b0;
    bit m_afull = 1'b0;
    bit m_ovf   = 1'b0;
    bit chk_en  = 1'b0;

    logic [PW-1:0] prev_g = '0;
    bit            prev_ok = 1'b0;

    function automatic logic [PW-1:0] gray(input int x);
        return PW'(x ^ (x >> 1));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy is writes minus reads; full is occupancy
    // equal to depth; overflow is a write request seen while full.
    always @(posedge clk or negedge rst_n) begin
        int acc;
        if (!rst_n) begin
            m_wbin  = 0;
            m_level = 0;
            m_full  = 1'b0;
            m_afull = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            acc = (winc && !m_full) ? 1 : 0;
            if (winc && m_full)
                m_ovf = 1'b1;
            else if (clr)
                m_ovf = 1'b0;
            m_wbin  = (m_wbin + acc) % MODV;
            m_level = (m_wbin - rd_cnt + MODV) % MODV;
            m_full  = (m_level == DEPTH);
            m_afull = (m_level >= TH);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("waddr",  64'(waddr),  64'(m_wbin % DEPTH));
            check("wptr_g", 64'(wptr_g), 64'(gray(m_wbin)));
            check("wlevel", 64'(wlevel), 64'(m_level));
            check("wfull",  64'(wfull),  64'(m_full));
            check("wafull", 64'(wafull), 64'(m_afull));
            check("wovf",   64'(wovf),   64'(m_ovf));
            if (rst_n && prev_ok)
                check("gray_step", 64'($countones(wptr_g ^ prev_g) <= 1), 64'(1));
            prev_g  = wptr_g;
            prev_ok = rst_n;
        end
    end

    // Drive one cycle of inputs at the current negedge, return at the next.
    task automatic step(input bit w, input bit rdadv, input bit c);
        winc = w;
        clr  = c;
        if (rdadv) rd_cnt = (rd_cnt + 1) % MODV;
        rptr = gray(rd_cnt);
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] a0;
        int lvl;

        chk_en = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        check("rst_waddr",  64'(waddr),  64'(0));
        check("rst_wptr_g", 64'(wptr_g), 64'(0));
        check("rst_wlevel", 64'(wlevel), 64'(0));
        check("rst_flags",  64'({wfull, wafull, wovf}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 16 back-to-back writes with the read pointer parked at 0.
        for (int i = 0; i < 16; i++) begin
            check("burst_waddr", 64'(waddr), 64'(i));
            step(1, 0, 0);
            check("burst_level", 64'(wlevel), 64'(i + 1));
            check("burst_afull", 64'(wafull), 64'((i + 1) >= 12));
            check("burst_full",  64'(wfull),  64'((i + 1) == 16));
        end
        check("full_wptr_g", 64'(wptr_g), 64'(5'b11000));

        // Writes while full are dropped and set the sticky overflow.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check("ovf_waddr",  64'(waddr),  64'(0));
            check("ovf_wptr_g", 64'(wptr_g), 64'(5'b11000));
            check("ovf_level",  64'(wlevel), 64'(16));
            check("ovf_set",    64'(wovf),   64'(1));
        end
        step(0, 0, 0);
        check("ovf_sticky", 64'(wovf), 64'(1));
        step(0, 0, 1);
        check("ovf_clear", 64'(wovf), 64'(0));
        step(1, 0, 1);
        check("ovf_set_wins", 64'(wovf), 64'(1));
        step(0, 0, 1);
        check("ovf_clear2", 64'(wovf), 64'(0));

        // Read pointer steps to Gray(1): full drops one edge later.
        step(0, 1, 0);
        check("rel_rptr",  64'(rptr),   64'(5'b00001));
        check("rel_full",  64'(wfull),  64'(0));
        check("rel_level", 64'(wlevel), 64'(15));
        check("rel_afull", 64'(wafull), 64'(1));

        // Reads tracking writes at distance 3 across several wraps.
        rd_cnt = 13;
        step(0, 0, 0);
        check("track_start", 64'(wlevel), 64'(3));
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 0);
            check("track_level", 64'(wlevel), 64'(3));
            check("track_full",  64'(wfull),  64'(0));
        end

        // Simultaneous write and read advance at level 8.
        rd_cnt = (m_wbin - 8 + MODV) % MODV;
        step(0, 0, 0);
        check("sim_level0", 64'(wlevel), 64'(8));
        a0 = waddr;
        step(1, 1, 0);
        check("sim_level", 64'(wlevel), 64'(8));
        check("sim_waddr", 64'(waddr),  64'(AW'(a0 + 1'b1)));

        // Randomized mix; reads never overtake accepted writes.
        for (int i = 0; i < 600; i++) begin
            lvl = (m_wbin - rd_cnt + MODV) % MODV;
            step(($urandom % 10) < 7,
                 (lvl > 0) && (($urandom % 10) < 4),
                 ($urandom % 20) == 0);
        end

        // Reset asserted mid-burst at level 10.
        winc = 1'b0;
        rd_cnt = (m_wbin - 10 + MODV) % MODV;
        step(0, 0, 0);
        check("pre_rst_level", 64'(wlevel), 64'(10));
        winc = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_waddr",  64'(waddr),  64'(0));
        check("mid_rst_wptr_g", 64'(wptr_g), 64'(0));
        check("mid_rst_wlevel", 64'(wlevel), 64'(0));
        check("mid_rst_flags",  64'({wfull, wafull, wovf}), 64'(0));
        @(negedge clk);
        rd_cnt = 0;
        rptr   = '0;
        winc   = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("post_rst_level", 64'(wlevel), 64'(5));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
